// File: rtl/valid_ready_slave.sv
// Valid/ready receive slave: buffers accepted beats in a small FIFO, drains them
// as a registered strobe, counts acceptances and flags breaks in the +1 sequence.
module valid_ready_slave #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_s_valid,
  input  logic [7:0]               i_s_data,
  input  logic                     i_s_stall,
  output logic                     o_s_ready,
  output logic [7:0]               o_s_data,
  output logic                     o_s_data_valid,
  output logic [$clog2(DEPTH):0]   o_s_level,
  output logic [15:0]              o_s_count,
  output logic                     o_s_seq_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_TRACK = 1'b1
  } chk_state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    data_q, data_d;
  logic          data_valid_q, data_valid_d;
  logic [15:0]   count_q, count_d;
  logic [7:0]    last_q, last_d;
  logic          seq_err_q, seq_err_d;
  chk_state_t    state_q, state_d;

  logic push;
  logic pop;

  // Ready depends on registered occupancy only, so a pop in the same cycle
  // never reopens a full FIFO.
  assign o_s_ready = (level_q != LW'(DEPTH));
  assign push      = i_s_valid & o_s_ready;
  assign pop       = (level_q != '0) & ~i_s_stall;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    count_d      = count_q;
    last_d       = last_q;
    seq_err_d    = seq_err_q;
    state_d      = state_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      count_d  = count_q + 16'd1;
    end

    if (pop) begin
      rd_ptr_d     = rd_ptr_q + AW'(1);
      data_d       = mem_q[rd_ptr_q];
      data_valid_d = 1'b1;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // The first beat after reset only seeds the reference value.
    if (push) begin
      last_d = i_s_data;
      case (state_q)
        ST_IDLE: begin
          state_d = ST_TRACK;
        end
        ST_TRACK: begin
          if (i_s_data != last_q + 8'd1) begin
            seq_err_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      count_q      <= '0;
      last_q       <= '0;
      seq_err_q    <= 1'b0;
      state_q      <= ST_IDLE;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      count_q      <= count_d;
      last_q       <= last_d;
      seq_err_q    <= seq_err_d;
      state_q      <= state_d;
    end
  end

  // Storage needs no reset; the pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_s_data;
    end
  end

  assign o_s_data       = data_q;
  assign o_s_data_valid = data_valid_q;
  assign o_s_level      = level_q;
  assign o_s_count      = count_q;
  assign o_s_seq_err    = seq_err_q;

endmodule

// File: tb/tb_valid_ready_slave.sv
// Directed bench for valid_ready_slave: a table of single-edge vectors with
// hand-computed results, followed by multi-cycle sequence, reset and wrap cases.
module tb_valid_ready_slave;

  logic       clk;
  logic       rst_n;
  logic       sValid;
  logic [7:0] sData;
  logic       sStall;
  logic       sReady;
  logic [7:0] outData;
  logic       outValid;
  logic [2:0] outLevel;
  logic [15:0] outCount;
  logic       seqErr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic       valid;
    logic [7:0] data;
    logic       stall;
    int         expReady;
    int         expLevel;
    int         expDv;
    int         expData;
    int         expCount;
    int         expErr;
  } vec_t;

  vec_t vecs[$];

  valid_ready_slave #(.DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_s_valid      (sValid),
    .i_s_data       (sData),
    .i_s_stall      (sStall),
    .o_s_ready      (sReady),
    .o_s_data       (outData),
    .o_s_data_valid (outValid),
    .o_s_level      (outLevel),
    .o_s_count      (outCount),
    .o_s_seq_err    (seqErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkField(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input int rdy, input int lvl, input int dv,
                             input int data, input int cnt, input int err);
    checkField({tag, ".ready"}, int'(sReady), rdy);
    checkField({tag, ".level"}, int'(outLevel), lvl);
    checkField({tag, ".data_valid"}, int'(outValid), dv);
    checkField({tag, ".data"}, int'(outData), data);
    checkField({tag, ".count"}, int'(outCount), cnt);
    checkField({tag, ".seq_err"}, int'(seqErr), err);
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic s);
    sValid = v;
    sData  = d;
    sStall = s;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input string tag);
    sValid = 1'b0;
    sData  = 8'd0;
    sStall = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    checkOutput(tag, 1, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  function automatic void addVec(input string tag, input logic v, input int d, input logic s,
                                 input int rdy, input int lvl, input int dv, input int data,
                                 input int cnt, input int err);
    vec_t e;
    e.tag = tag; e.valid = v; e.data = 8'(d); e.stall = s;
    e.expReady = rdy; e.expLevel = lvl; e.expDv = dv; e.expData = data;
    e.expCount = cnt; e.expErr = err;
    vecs.push_back(e);
  endfunction

  initial begin
    rst_n  = 1'b0;
    sValid = 1'b0;
    sData  = 8'd0;
    sStall = 1'b0;

    // Streaming 0..9: each beat drains one edge after acceptance.
    addVec("stream0", 1, 0, 0, 1, 1, 0, 0, 1, 0);
    for (int i = 1; i < 10; i++) addVec("stream", 1, i, 0, 1, 1, 1, i - 1, i + 1, 0);
    addVec("streamTail", 0, 0, 0, 1, 0, 1, 9, 10, 0);
    addVec("streamIdle", 0, 0, 0, 1, 0, 0, 9, 10, 0);
    // Fill under stall; the fifth beat is refused.
    addVec("fill10", 1, 10, 1, 1, 1, 0, 9, 11, 0);
    addVec("fill11", 1, 11, 1, 1, 2, 0, 9, 12, 0);
    addVec("fill12", 1, 12, 1, 1, 3, 0, 9, 13, 0);
    addVec("fill13", 1, 13, 1, 0, 4, 0, 9, 14, 0);
    addVec("fill14", 1, 14, 1, 0, 4, 0, 9, 14, 0);
    // Pop while full: ready was 0, so beat 99 is ignored.
    addVec("drain10", 1, 99, 0, 1, 3, 1, 10, 14, 0);
    addVec("drain11", 0, 0, 0, 1, 2, 1, 11, 14, 0);
    addVec("drain12", 0, 0, 0, 1, 1, 1, 12, 14, 0);
    addVec("drain13", 0, 0, 0, 1, 0, 1, 13, 14, 0);
    addVec("drainIdle", 0, 0, 0, 1, 0, 0, 13, 14, 0);
    // Push and pop together at level 2.
    addVec("sim14", 1, 14, 1, 1, 1, 0, 13, 15, 0);
    addVec("sim15", 1, 15, 1, 1, 2, 0, 13, 16, 0);
    addVec("sim16", 1, 16, 0, 1, 2, 1, 14, 17, 0);
    addVec("sim17", 1, 17, 0, 1, 2, 1, 15, 18, 0);
    addVec("simTail16", 0, 0, 0, 1, 1, 1, 16, 18, 0);
    addVec("simTail17", 0, 0, 0, 1, 0, 1, 17, 18, 0);

    #2;
    doReset("reset");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].valid, vecs[i].data, vecs[i].stall);
      checkOutput(vecs[i].tag, vecs[i].expReady, vecs[i].expLevel, vecs[i].expDv,
                  vecs[i].expData, vecs[i].expCount, vecs[i].expErr);
    end

    // Sequence wrap 254,255,0,1 is legal; 3 breaks it and the flag sticks.
    doReset("resetWrap");
    applyStimulus(1, 8'd254, 0);
    applyStimulus(1, 8'd255, 0);
    applyStimulus(1, 8'd0, 0);
    applyStimulus(1, 8'd1, 0);
    checkField("wrap.seq_err", int'(seqErr), 0);
    checkField("wrap.count", int'(outCount), 4);
    applyStimulus(1, 8'd3, 0);
    checkField("skip.seq_err", int'(seqErr), 1);
    for (int i = 4; i < 24; i++) begin
      applyStimulus(1, 8'(i), 0);
      checkField("sticky.seq_err", int'(seqErr), 1);
    end
    applyStimulus(0, 8'd0, 0);

    // Asynchronous reset with three beats buffered.
    applyStimulus(1, 8'd24, 1);
    applyStimulus(1, 8'd25, 1);
    applyStimulus(1, 8'd26, 1);
    checkField("preReset.level", int'(outLevel), 3);
    sValid = 1'b0;
    sStall = 1'b0;
    rst_n  = 1'b0;
    #1;
    checkOutput("midReset", 1, 0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b1;
    applyStimulus(1, 8'd77, 0);
    checkOutput("post77", 1, 1, 0, 0, 1, 0);
    applyStimulus(1, 8'd78, 0);
    checkOutput("post78", 1, 1, 1, 77, 2, 0);
    applyStimulus(0, 8'd0, 0);
    checkOutput("postTail", 1, 0, 1, 78, 2, 0);
    applyStimulus(0, 8'd0, 0);
    checkOutput("postIdle", 1, 0, 0, 78, 2, 0);

    // 65536 accepted beats bring the counter back to zero.
    doReset("resetCount");
    for (int i = 0; i < 65536; i++) begin
      applyStimulus(1, 8'(i), 0);
      if (i == 65534) checkField("count.max", int'(outCount), 65535);
    end
    checkField("count.wrap", int'(outCount), 0);
    checkField("count.seq_err", int'(seqErr), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
